// File: rtl/dflow_pkg.sv
// Shared defaults, replay FSM state encoding and small helpers for the dataflow replay path.
package dflow_pkg;

    localparam int unsigned FIFO_DATA_WIDTH_DEF = 144;
    localparam int unsigned MEM_ADDR_WIDTH_DEF  = 19;
    localparam int unsigned MEM_DATA_WIDTH_DEF  = 144;
    localparam int unsigned MAX_OUTSTANDING_DEF = 16;
    localparam int unsigned STATE_W             = 3;

    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_CAL = 3'd1;
    localparam logic [STATE_W-1:0] ST_READ     = 3'd2;
    localparam logic [STATE_W-1:0] ST_DRAIN    = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE     = 3'd4;

    // Counter width able to hold the values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_rd_credit.sv
// Tracks reads in flight and decides whether another read may be issued.
// A return with nothing outstanding is flagged as an error and not accepted.
module mem_rd_credit
    import dflow_pkg::*;
#(
    parameter  int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    localparam int unsigned CNT_W           = cnt_width(MAX_OUTSTANDING)
)(
    input  logic clk,
    input  logic rst,
    input  logic sw_rst,
    input  logic issue,
    input  logic rd_valid,
    output logic can_issue_c,
    output logic rd_accept_c,
    output logic rd_err_c,
    output logic idle_c
);

    logic [CNT_W-1:0] outstanding;

    // Issue permit and return classification.
    always_comb begin
        can_issue_c = (outstanding < CNT_W'(MAX_OUTSTANDING));
        rd_accept_c = rd_valid && (outstanding != '0);
        rd_err_c    = rd_valid && (outstanding == '0);
        idle_c      = (outstanding == '0) && !rd_valid;
    end

    // Outstanding count: +1 on issue, -1 on accepted return, hold when both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else if (sw_rst) begin
            outstanding <= '0;
        end else begin
            case ({issue && can_issue_c, rd_accept_c})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: rtl/mem_to_fifo.sv
// Replays a stored tuple region from memory into an output FIFO.
// Read commands are registered: the permit is evaluated on a clock edge and
// app_rd_cmd/app_rd_addr present that read for the following cycle.
module mem_to_fifo
    import dflow_pkg::*;
#(
    parameter int unsigned FIFO_DATA_WIDTH = FIFO_DATA_WIDTH_DEF,
    parameter int unsigned MEM_ADDR_WIDTH  = MEM_ADDR_WIDTH_DEF,
    parameter int unsigned MEM_DATA_WIDTH  = MEM_DATA_WIDTH_DEF,
    parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sw_rst,
    input  logic                       cal_done,
    input  logic                       start_replay,
    input  logic                       loop_en,
    input  logic [MEM_ADDR_WIDTH-1:0]  dflow_addr_low,
    input  logic [MEM_ADDR_WIDTH-1:0]  dflow_addr_end,
    output logic                       app_rd_cmd,
    output logic [MEM_ADDR_WIDTH-1:0]  app_rd_addr,
    input  logic                       app_rd_valid,
    input  logic [MEM_DATA_WIDTH-1:0]  app_rd_data,
    output logic                       fifo_wr_en,
    output logic [FIFO_DATA_WIDTH-1:0] fifo_data,
    input  logic                       fifo_prog_full,
    output logic [31:0]                pass_count,
    output logic                       replay_done,
    output logic                       rd_err
);

    if (MEM_DATA_WIDTH != FIFO_DATA_WIDTH) begin : g_width_check
        $error("mem_to_fifo: MEM_DATA_WIDTH must equal FIFO_DATA_WIDTH");
    end

    logic [STATE_W-1:0]        state, state_next;
    logic [MEM_ADDR_WIDTH-1:0] rd_ptr, rd_ptr_next;
    logic [MEM_ADDR_WIDTH-1:0] lat_low, lat_low_next;
    logic [MEM_ADDR_WIDTH-1:0] lat_end, lat_end_next;
    logic [31:0]               pass_next;
    logic                      issue_c;
    logic                      last_c;
    logic                      can_issue_c;
    logic                      rd_accept_c;
    logic                      rd_err_c;
    logic                      idle_c;

    mem_rd_credit #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credit (
        .clk         (clk),
        .rst         (rst),
        .sw_rst      (sw_rst),
        .issue       (issue_c),
        .rd_valid    (app_rd_valid),
        .can_issue_c (can_issue_c),
        .rd_accept_c (rd_accept_c),
        .rd_err_c    (rd_err_c),
        .idle_c      (idle_c)
    );

    assign last_c = (rd_ptr == (lat_end - MEM_ADDR_WIDTH'(1)));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (sw_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, read issue and address/pass bookkeeping.
    always_comb begin
        state_next   = state;
        rd_ptr_next  = rd_ptr;
        lat_low_next = lat_low;
        lat_end_next = lat_end;
        pass_next    = pass_count;
        issue_c      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_replay) begin
                    state_next   = ST_WAIT_CAL;
                    lat_low_next = dflow_addr_low;
                    lat_end_next = dflow_addr_end;
                    rd_ptr_next  = dflow_addr_low;
                end
            end
            ST_WAIT_CAL: begin
                if (!start_replay) begin
                    state_next = ST_DRAIN;
                end else if (cal_done) begin
                    state_next = (lat_end == lat_low) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (!start_replay) begin
                    state_next = ST_DRAIN;
                end else if (cal_done && !fifo_prog_full && can_issue_c) begin
                    issue_c = 1'b1;
                    if (last_c) begin
                        pass_next = pass_count + 32'd1;
                        if (loop_en) begin
                            rd_ptr_next = lat_low;
                        end else begin
                            rd_ptr_next = rd_ptr + MEM_ADDR_WIDTH'(1);
                            state_next  = ST_DRAIN;
                        end
                    end else begin
                        rd_ptr_next = rd_ptr + MEM_ADDR_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (idle_c) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start_replay) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr      <= '0;
            lat_low     <= '0;
            lat_end     <= '0;
            pass_count  <= '0;
            app_rd_cmd  <= 1'b0;
            app_rd_addr <= '0;
            fifo_wr_en  <= 1'b0;
            fifo_data   <= '0;
            replay_done <= 1'b0;
            rd_err      <= 1'b0;
        end else if (sw_rst) begin
            rd_ptr      <= '0;
            lat_low     <= '0;
            lat_end     <= '0;
            pass_count  <= '0;
            app_rd_cmd  <= 1'b0;
            app_rd_addr <= '0;
            fifo_wr_en  <= 1'b0;
            fifo_data   <= '0;
            replay_done <= 1'b0;
            rd_err      <= 1'b0;
        end else begin
            rd_ptr      <= rd_ptr_next;
            lat_low     <= lat_low_next;
            lat_end     <= lat_end_next;
            pass_count  <= pass_next;
            app_rd_cmd  <= issue_c;
            app_rd_addr <= issue_c ? rd_ptr : app_rd_addr;
            fifo_wr_en  <= rd_accept_c;
            fifo_data   <= rd_accept_c ? FIFO_DATA_WIDTH'(app_rd_data) : fifo_data;
            replay_done <= (state_next == ST_DONE);
            rd_err      <= rd_err | rd_err_c;
        end
    end

endmodule

// File: tb/tb_mem_to_fifo.sv
// Bench for mem_to_fifo: behavioural memory with programmable latency plus a
// reference of the expected address/data stream derived from the region rules.
module tb_mem_to_fifo;

    logic          clk = 1'b0;
    logic          rst;
    logic          sw_rst;
    logic          cal_done;
    logic          start_replay;
    logic          loop_en;
    logic [18:0]   dflow_addr_low;
    logic [18:0]   dflow_addr_end;
    logic          app_rd_cmd;
    logic [18:0]   app_rd_addr;
    logic          app_rd_valid = 1'b0;
    logic [143:0]  app_rd_data  = '0;
    logic          fifo_wr_en;
    logic [143:0]  fifo_data;
    logic          fifo_prog_full;
    logic [31:0]   pass_count;
    logic          replay_done;
    logic          rd_err;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    typedef struct packed {
        logic [18:0] addr;
        logic [31:0] due;
    } pend_t;

    pend_t        pend_q[$];
    pend_t        pend_head;
    logic [18:0]  cmd_q[$];
    logic [143:0] wr_q[$];
    int unsigned  cyc = 0;
    int unsigned  lat = 5;
    int unsigned  inj_req = 0;
    int unsigned  inj_ack = 0;
    int unsigned  max_inflight = 0;
    int unsigned  pf_viol = 0;
    logic [17:0]  salt;
    logic [31:0]  exp_pass = 0;

    mem_to_fifo u_dut (
        .clk            (clk),
        .rst            (rst),
        .sw_rst         (sw_rst),
        .cal_done       (cal_done),
        .start_replay   (start_replay),
        .loop_en        (loop_en),
        .dflow_addr_low (dflow_addr_low),
        .dflow_addr_end (dflow_addr_end),
        .app_rd_cmd     (app_rd_cmd),
        .app_rd_addr    (app_rd_addr),
        .app_rd_valid   (app_rd_valid),
        .app_rd_data    (app_rd_data),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_data      (fifo_data),
        .fifo_prog_full (fifo_prog_full),
        .pass_count     (pass_count),
        .replay_done    (replay_done),
        .rd_err         (rd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [143:0] mem_word(input logic [18:0] a);
        logic [17:0] s;
        s = a[17:0] ^ salt;
        return {8{s}};
    endfunction

    // Memory model and output logger, sampled 1ns after each rising edge.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (fifo_wr_en) wr_q.push_back(fifo_data);
        if (app_rd_cmd) begin
            cmd_q.push_back(app_rd_addr);
            if (fifo_prog_full) pf_viol++;
            pend_q.push_back('{addr: app_rd_addr, due: cyc + lat});
        end
        if (pend_q.size() > max_inflight) max_inflight = pend_q.size();
        app_rd_valid = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            pend_head    = pend_q.pop_front();
            app_rd_valid = 1'b1;
            app_rd_data  = mem_word(pend_head.addr);
        end else if (inj_req != inj_ack) begin
            inj_ack++;
            app_rd_valid = 1'b1;
            for (int k = 0; k < 5; k++) app_rd_data[k*32 +: 16] = 16'($urandom);
        end
    end

    task automatic clear_logs();
        cmd_q.delete();
        wr_q.delete();
        max_inflight = 0;
        pf_viol      = 0;
    endtask

    task automatic begin_replay(input logic [18:0] low, input logic [18:0] hi, input logic lp);
        @(negedge clk);
        clear_logs();
        dflow_addr_low = low;
        dflow_addr_end = hi;
        loop_en        = lp;
        start_replay   = 1'b1;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (replay_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cmds(input int unsigned n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cmd_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Compares logged reads and FIFO writes against an expected address list.
    task automatic check_stream(input string tag, input logic [18:0] exp_addr[$]);
        checks++;
        if (cmd_q.size() !== exp_addr.size()) begin
            failures++;
            $display("FAIL %s read count: got %0d expected %0d", tag, cmd_q.size(), exp_addr.size());
        end
        checks++;
        if (wr_q.size() !== exp_addr.size()) begin
            failures++;
            $display("FAIL %s write count: got %0d expected %0d", tag, wr_q.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i < cmd_q.size()) begin
                checks++;
                if (cmd_q[i] !== exp_addr[i]) begin
                    failures++;
                    $display("FAIL %s read addr[%0d]: got %h expected %h", tag, i, cmd_q[i], exp_addr[i]);
                end
            end
            if (i < wr_q.size()) begin
                checks++;
                if (wr_q[i] !== mem_word(exp_addr[i])) begin
                    failures++;
                    $display("FAIL %s write data[%0d]: got %h expected %h", tag, i, wr_q[i], mem_word(exp_addr[i]));
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sw_rst = 1'b0; cal_done = 1'b0; start_replay = 1'b0; loop_en = 1'b0;
        dflow_addr_low = '0; dflow_addr_end = '0; fifo_prog_full = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (app_rd_cmd !== 1'b0)   begin failures++; $display("FAIL reset app_rd_cmd: got %b expected 0", app_rd_cmd); end
        checks++; if (app_rd_addr !== '0)    begin failures++; $display("FAIL reset app_rd_addr: got %h expected 0", app_rd_addr); end
        checks++; if (fifo_wr_en !== 1'b0)   begin failures++; $display("FAIL reset fifo_wr_en: got %b expected 0", fifo_wr_en); end
        checks++; if (fifo_data !== '0)      begin failures++; $display("FAIL reset fifo_data: got %h expected 0", fifo_data); end
        checks++; if (pass_count !== 32'd0)  begin failures++; $display("FAIL reset pass_count: got %0d expected 0", pass_count); end
        checks++; if (replay_done !== 1'b0)  begin failures++; $display("FAIL reset replay_done: got %b expected 0", replay_done); end
        checks++; if (rd_err !== 1'b0)       begin failures++; $display("FAIL reset rd_err: got %b expected 0", rd_err); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_pass();
        logic [18:0] exp_addr[$];
        bit ok;
        lat = 5;
        begin_replay(19'h10, 19'h14, 1'b0);
        repeat (2) @(negedge clk);
        dflow_addr_low = 19'($urandom);
        dflow_addr_end = 19'($urandom);
        repeat (4) @(negedge clk);
        checks++;
        if (cmd_q.size() !== 0) begin failures++; $display("FAIL single reads before cal_done: got %0d expected 0", cmd_q.size()); end
        cal_done = 1'b1;
        wait_done(200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL single replay_done timeout: got 0 expected 1"); end
        for (int a = 16'h10; a < 16'h14; a++) exp_addr.push_back(19'(a));
        exp_pass = exp_pass + 32'd1;
        check_stream("single", exp_addr);
        checks++;
        if (pass_count !== exp_pass) begin failures++; $display("FAIL single pass_count: got %0d expected %0d", pass_count, exp_pass); end
        repeat (3) @(negedge clk);
        checks++;
        if (replay_done !== 1'b1) begin failures++; $display("FAIL single done hold: got %b expected 1", replay_done); end
        start_replay = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (replay_done !== 1'b0) begin failures++; $display("FAIL single done release: got %b expected 0", replay_done); end
        checks++;
        if (rd_err !== 1'b0) begin failures++; $display("FAIL single rd_err: got %b expected 0", rd_err); end
    endtask

    task automatic test_loop();
        logic [18:0] exp_addr[$];
        bit ok;
        lat = 5;
        begin_replay(19'h10, 19'h14, 1'b1);
        wait_cmds(12, 200, ok);
        start_replay = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL loop issue timeout: got %0d reads expected 12", cmd_q.size()); end
        wait_done(200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL loop replay_done timeout: got 0 expected 1"); end
        for (int i = 0; i < 12; i++) exp_addr.push_back(19'(16'h10 + (i % 4)));
        exp_pass = exp_pass + 32'd3;
        check_stream("loop", exp_addr);
        checks++;
        if (pass_count !== exp_pass) begin failures++; $display("FAIL loop pass_count: got %0d expected %0d", pass_count, exp_pass); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [18:0] exp_addr[$];
        logic [18:0] low;
        int unsigned n;
        int unsigned wr_before;
        int unsigned cmd_before;
        bit ok;
        lat = 30;
        low = 19'($urandom_range(0, 4000));
        n   = $urandom_range(40, 60);
        begin_replay(low, low + 19'(n), 1'b0);
        wait_cmds(8, 200, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bp first reads timeout: got %0d expected 8", cmd_q.size()); end
        fifo_prog_full = 1'b1;
        wr_before  = wr_q.size();
        repeat (2) @(negedge clk);
        cmd_before = cmd_q.size();
        repeat (40) @(negedge clk);
        checks++;
        if (cmd_q.size() !== cmd_before) begin failures++; $display("FAIL bp reads while full: got %0d expected %0d", cmd_q.size(), cmd_before); end
        checks++;
        if (wr_q.size() <= wr_before) begin failures++; $display("FAIL bp writes while full: got %0d expected more than %0d", wr_q.size(), wr_before); end
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (replay_done) begin ok = 1'b1; break; end
            fifo_prog_full = ($urandom_range(0, 3) == 0);
        end
        fifo_prog_full = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL bp replay_done timeout: got 0 expected 1"); end
        checks++;
        if (pf_viol !== 0) begin failures++; $display("FAIL bp cmd under prog_full: got %0d expected 0", pf_viol); end
        checks++;
        if (max_inflight !== 16) begin failures++; $display("FAIL bp max in flight: got %0d expected 16", max_inflight); end
        for (int i = 0; i < int'(n); i++) exp_addr.push_back(low + 19'(i));
        exp_pass = exp_pass + 32'd1;
        check_stream("bp", exp_addr);
        checks++;
        if (pass_count !== exp_pass) begin failures++; $display("FAIL bp pass_count: got %0d expected %0d", pass_count, exp_pass); end
        start_replay = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_empty();
        logic [18:0] exp_addr[$];
        bit ok;
        lat = 5;
        begin_replay(19'h20, 19'h20, 1'b0);
        wait_done(50, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL empty replay_done timeout: got 0 expected 1"); end
        repeat (3) @(negedge clk);
        check_stream("empty", exp_addr);
        checks++;
        if (pass_count !== exp_pass) begin failures++; $display("FAIL empty pass_count: got %0d expected %0d", pass_count, exp_pass); end
        start_replay = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_spurious();
        @(negedge clk);
        clear_logs();
        inj_req++;
        repeat (4) @(negedge clk);
        checks++;
        if (rd_err !== 1'b1) begin failures++; $display("FAIL spurious rd_err: got %b expected 1", rd_err); end
        checks++;
        if (wr_q.size() !== 0) begin failures++; $display("FAIL spurious fifo writes: got %0d expected 0", wr_q.size()); end
    endtask

    task automatic test_abort_swrst();
        logic [18:0] exp_addr[$];
        bit ok;
        lat = 8;
        begin_replay(19'h40, 19'h80, 1'b0);
        wait_cmds(5, 100, ok);
        start_replay = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL abort issue timeout: got %0d expected 5", cmd_q.size()); end
        wait_done(100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL abort replay_done timeout: got 0 expected 1"); end
        for (int i = 0; i < 5; i++) exp_addr.push_back(19'(16'h40 + i));
        check_stream("abort", exp_addr);
        checks++;
        if (pass_count !== exp_pass) begin failures++; $display("FAIL abort pass_count: got %0d expected %0d", pass_count, exp_pass); end
        repeat (2) @(negedge clk);
        checks++;
        if (replay_done !== 1'b0) begin failures++; $display("FAIL abort back to idle: got %b expected 0", replay_done); end
        sw_rst = 1'b1;
        @(negedge clk);
        checks++; if (app_rd_cmd !== 1'b0)   begin failures++; $display("FAIL swrst app_rd_cmd: got %b expected 0", app_rd_cmd); end
        checks++; if (app_rd_addr !== '0)    begin failures++; $display("FAIL swrst app_rd_addr: got %h expected 0", app_rd_addr); end
        checks++; if (fifo_wr_en !== 1'b0)   begin failures++; $display("FAIL swrst fifo_wr_en: got %b expected 0", fifo_wr_en); end
        checks++; if (fifo_data !== '0)      begin failures++; $display("FAIL swrst fifo_data: got %h expected 0", fifo_data); end
        checks++; if (pass_count !== 32'd0)  begin failures++; $display("FAIL swrst pass_count: got %0d expected 0", pass_count); end
        checks++; if (replay_done !== 1'b0)  begin failures++; $display("FAIL swrst replay_done: got %b expected 0", replay_done); end
        checks++; if (rd_err !== 1'b0)       begin failures++; $display("FAIL swrst rd_err: got %b expected 0", rd_err); end
        sw_rst = 1'b0;
        exp_pass = 32'd0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        salt = 18'($urandom);
        test_reset();
        test_single_pass();
        test_loop();
        test_backpressure();
        test_empty();
        test_spurious();
        test_abort_swrst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
